tcp_client_conn: RTL and testbench

TCP_CLIENT_CONN -- requirements
Module: tcp_client_conn

---
 rtl/tcp_client_conn_if.sv | 42 ++++
 rtl/tcp_client_conn.sv | 197 +++++++++++++++++++
 tb/tb_tcp_client_conn.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_client_conn_if.sv
// Receive and transmit segment channels between the TCP client connection block and the network side.
// Latency: none; this is wiring only.
// Backpressure: rx uses valid/ready, and tx uses valid/ready with the fields held stable while stalled.
interface tcp_client_conn_if;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_SYN;
    logic        rx_ACK;
    logic        rx_FIN;
    logic        rx_RST;
    logic [31:0] rx_seq;
    logic [31:0] rx_ack;
    logic [15:0] rx_src_port;
    logic [15:0] rx_dst_port;

    logic        tx_valid;
    logic        tx_ready;
    logic        tx_SYN;
    logic        tx_ACK;
    logic        tx_FIN;
    logic        tx_RST;
    logic [31:0] tx_seq;
    logic [31:0] tx_ack;
    logic [15:0] tx_src_port;
    logic [15:0] tx_dst_port;

    // Connection block side
    modport master (
        input  rx_valid, rx_SYN, rx_ACK, rx_FIN, rx_RST, rx_seq, rx_ack, rx_src_port, rx_dst_port,
        output rx_ready,
        output tx_valid, tx_SYN, tx_ACK, tx_FIN, tx_RST, tx_seq, tx_ack, tx_src_port, tx_dst_port,
        input  tx_ready
    );

    // Network side
    modport slave (
        output rx_valid, rx_SYN, rx_ACK, rx_FIN, rx_RST, rx_seq, rx_ack, rx_src_port, rx_dst_port,
        input  rx_ready,
        input  tx_valid, tx_SYN, tx_ACK, tx_FIN, tx_RST, tx_seq, tx_ack, tx_src_port, tx_dst_port,
        output tx_ready
    );
endinterface

// File: rtl/tcp_client_conn.sv
// TCP client connection FSM: active open and close, passive close, retransmit timeout and RST handling.
// Latency: a consumed segment or request produces its response on tx_valid one cycle later.
// Backpressure: one segment can be in flight; rx_ready is low while tx_valid is high, and tx fields hold until they are accepted.
module tcp_client_conn #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                connect_req,
    input  logic                close_req,
    input  logic [15:0]         loc_port_in,
    input  logic [15:0]         rem_port_in,
    input  logic [31:0]         isn_in,
    tcp_client_conn_if.master   seg,
    output logic [2:0]          state_out,
    output logic                established_out,
    output logic                error_out
);
    typedef enum logic [2:0] {
        S_CLOSED      = 3'd0,
        S_SYN_SENT    = 3'd1,
        S_ESTABLISHED = 3'd2,
        S_FIN_WAIT_1  = 3'd3,
        S_FIN_WAIT_2  = 3'd4,
        S_TIME_WAIT   = 3'd5,
        S_LAST_ACK    = 3'd6
    } state_t;

    // The timer must reach 2*TIMEOUT_CYC-1 in TIME_WAIT.
    localparam int TW = $clog2(2 * TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic [31:0]   snd_nxt, rcv_nxt, snd_d, rcv_d;
    logic [15:0]   loc_port_q, rem_port_q;
    logic          tx_valid_q, tx_syn_q, tx_ack_q, tx_fin_q, tx_rst_q;
    logic [31:0]   tx_seq_q, tx_ack_num_q;

    logic          emit, e_syn, e_ack, e_fin, e_rst, latch, retrans, err_d;
    logic [31:0]   e_seq, e_ack_num;
    logic          seg_ok, timed, timeout;

    // Decode the current segment and the retransmit timer
    always_comb begin
        seg_ok  = seg.rx_valid && !tx_valid_q &&
                  seg.rx_dst_port == loc_port_q && seg.rx_src_port == rem_port_q;
        timed   = (state == S_SYN_SENT) || (state == S_FIN_WAIT_1) || (state == S_LAST_ACK);
        timeout = timed && !tx_valid_q && timer == TW'(TIMEOUT_CYC - 1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_CLOSED;
        else     state <= state_nxt;
    end

    // Next state and the segment to emit. Segments take priority over close_req and timeout.
    always_comb begin
        state_nxt = state;
        emit = 1'b0; e_syn = 1'b0; e_ack = 1'b0; e_fin = 1'b0; e_rst = 1'b0;
        e_seq = 32'd0; e_ack_num = 32'd0;
        snd_d = snd_nxt; rcv_d = rcv_nxt;
        latch = 1'b0; retrans = 1'b0; err_d = 1'b0;
        case (state)
            S_CLOSED: begin
                if (connect_req && !tx_valid_q) begin
                    latch = 1'b1; snd_d = isn_in;
                    emit = 1'b1; e_syn = 1'b1; e_seq = isn_in;
                    state_nxt = S_SYN_SENT;
                end
            end
            S_TIME_WAIT: begin
                if (timer == TW'(2 * TIMEOUT_CYC - 1)) state_nxt = S_CLOSED;
            end
            default: begin
                if (seg_ok && seg.rx_RST) begin
                    state_nxt = S_CLOSED; err_d = 1'b1;
                end else if (seg_ok) begin
                    case (state)
                        S_SYN_SENT: begin
                            if (seg.rx_SYN && seg.rx_ACK) begin
                                if (seg.rx_ack == snd_nxt + 32'd1) begin
                                    snd_d = snd_nxt + 32'd1; rcv_d = seg.rx_seq + 32'd1;
                                    emit = 1'b1; e_ack = 1'b1;
                                    e_seq = snd_nxt + 32'd1; e_ack_num = seg.rx_seq + 32'd1;
                                    state_nxt = S_ESTABLISHED;
                                end else begin
                                    emit = 1'b1; e_rst = 1'b1; e_seq = seg.rx_ack;
                                end
                            end
                        end
                        S_ESTABLISHED: begin
                            if (seg.rx_FIN) begin
                                rcv_d = seg.rx_seq + 32'd1;
                                emit = 1'b1; e_fin = 1'b1; e_ack = 1'b1;
                                e_seq = snd_nxt; e_ack_num = seg.rx_seq + 32'd1;
                                state_nxt = S_LAST_ACK;
                            end
                        end
                        S_FIN_WAIT_1: begin
                            if (seg.rx_ACK && seg.rx_ack == snd_nxt + 32'd1) begin
                                snd_d = snd_nxt + 32'd1;
                                if (seg.rx_FIN) begin
                                    rcv_d = seg.rx_seq + 32'd1;
                                    emit = 1'b1; e_ack = 1'b1;
                                    e_seq = snd_nxt + 32'd1; e_ack_num = seg.rx_seq + 32'd1;
                                    state_nxt = S_TIME_WAIT;
                                end else begin
                                    state_nxt = S_FIN_WAIT_2;
                                end
                            end
                        end
                        S_FIN_WAIT_2: begin
                            if (seg.rx_FIN) begin
                                rcv_d = seg.rx_seq + 32'd1;
                                emit = 1'b1; e_ack = 1'b1;
                                e_seq = snd_nxt; e_ack_num = seg.rx_seq + 32'd1;
                                state_nxt = S_TIME_WAIT;
                            end
                        end
                        S_LAST_ACK: begin
                            if (seg.rx_ACK && seg.rx_ack == snd_nxt + 32'd1) state_nxt = S_CLOSED;
                        end
                        default: ;
                    endcase
                end else if (state == S_ESTABLISHED && close_req && !tx_valid_q) begin
                    // A level close request waits until any pending segment has been sent.
                    emit = 1'b1; e_fin = 1'b1; e_ack = 1'b1;
                    e_seq = snd_nxt; e_ack_num = rcv_nxt;
                    state_nxt = S_FIN_WAIT_1;
                end else if (timeout) begin
                    if (retry == RW'(MAX_RETRY)) begin
                        state_nxt = S_CLOSED; err_d = 1'b1;
                    end else begin
                        retrans = 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs that follow the state directly
    always_comb begin
        state_out       = state;
        established_out = (state == S_ESTABLISHED);
        seg.rx_ready    = !tx_valid_q;
    end

    // Datapath registers: tx segment, sequence numbers, timer and retry count
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_q <= 1'b0; tx_syn_q <= 1'b0; tx_ack_q <= 1'b0; tx_fin_q <= 1'b0; tx_rst_q <= 1'b0;
            tx_seq_q <= '0; tx_ack_num_q <= '0;
            loc_port_q <= '0; rem_port_q <= '0;
            snd_nxt <= '0; rcv_nxt <= '0;
            timer <= '0; retry <= '0; error_out <= 1'b0;
        end else begin
            error_out <= err_d;
            snd_nxt   <= snd_d;
            rcv_nxt   <= rcv_d;
            if (latch) begin
                loc_port_q <= loc_port_in;
                rem_port_q <= rem_port_in;
            end
            // A retransmit re-raises valid and keeps the held fields of the last segment.
            if (emit) begin
                tx_valid_q <= 1'b1;
                tx_syn_q <= e_syn; tx_ack_q <= e_ack; tx_fin_q <= e_fin; tx_rst_q <= e_rst;
                tx_seq_q <= e_seq; tx_ack_num_q <= e_ack_num;
            end else if (retrans) begin
                tx_valid_q <= 1'b1;
            end else if (tx_valid_q && seg.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            if (state_nxt != state) retry <= '0;
            else if (retrans)       retry <= retry + RW'(1);
            // TIME_WAIT runs on wall-clock cycles, so its timer ignores acceptance of the final ACK.
            if (state_nxt != state)                timer <= '0;
            else if (state == S_TIME_WAIT)         timer <= timer + TW'(1);
            else if (tx_valid_q && seg.tx_ready)   timer <= '0;
            else if (timed && !tx_valid_q)         timer <= timeout ? '0 : timer + TW'(1);
        end
    end

    assign seg.tx_valid    = tx_valid_q;
    assign seg.tx_SYN      = tx_syn_q;
    assign seg.tx_ACK      = tx_ack_q;
    assign seg.tx_FIN      = tx_fin_q;
    assign seg.tx_RST      = tx_rst_q;
    assign seg.tx_seq      = tx_seq_q;
    assign seg.tx_ack      = tx_ack_num_q;
    assign seg.tx_src_port = loc_port_q;
    assign seg.tx_dst_port = rem_port_q;
endmodule

// File: tb/tb_tcp_client_conn.sv
// Bench for tcp_client_conn: directed peer segments against a queue of expected emitted segments.
// Latency: an expected segment is matched at each cycle it is offered and removed when it is accepted.
// Backpressure: tx_ready is held low in selected windows to check that fields stay stable and rx_ready stays low.
`timescale 1ns/1ps
module tb_tcp_client_conn;
    localparam int          T   = 8;
    localparam int          MR  = 3;
    localparam logic [15:0] LOC = 16'h1234;
    localparam logic [15:0] REM = 16'h0050;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        connect_req = 1'b0;
    logic        close_req = 1'b0;
    logic [15:0] loc_port_in = LOC;
    logic [15:0] rem_port_in = REM;
    logic [31:0] isn_in = 32'd0;
    logic [2:0]  state_out;
    logic        established_out;
    logic        error_out;

    tcp_client_conn_if seg();

    tcp_client_conn #(.TIMEOUT_CYC(T), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .connect_req(connect_req), .close_req(close_req),
        .loc_port_in(loc_port_in), .rem_port_in(rem_port_in), .isn_in(isn_in),
        .seg(seg), .state_out(state_out), .established_out(established_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        syn;
        logic        ackf;
        logic        fin;
        logic        rstf;
        logic [31:0] seq;
        logic [31:0] ackn;
    } seg_t;

    seg_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   err_cnt = 0;
    int   e0;
    int   n;

    function automatic seg_t mk(input logic s, a, f, r, input logic [31:0] sq, ak);
        mk = {s, a, f, r, sq, ak};
    endfunction

    function automatic logic [99:0] tx_now();
        return {seg.tx_SYN, seg.tx_ACK, seg.tx_FIN, seg.tx_RST, seg.tx_seq, seg.tx_ack,
                seg.tx_src_port, seg.tx_dst_port};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_seg(input string name, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Each offered tx segment must equal the head of the expected queue until it is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            if (error_out) err_cnt++;
            if (seg.tx_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %h, expected no segment", tx_now());
                end else begin
                    chk_seg("tx_segment", tx_now(), {exp_q[0], LOC, REM});
                    if (seg.tx_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, a, f, r, input logic [31:0] sq, ak,
                        input logic [15:0] src = REM, input logic [15:0] dst = LOC);
        int k = 0;
        while (!seg.rx_ready && k < 30) begin
            tick();
            k++;
        end
        chk("send_rx_ready", 32'(seg.rx_ready), 32'd1);
        seg.rx_valid = 1'b1;
        seg.rx_SYN = s; seg.rx_ACK = a; seg.rx_FIN = f; seg.rx_RST = r;
        seg.rx_seq = sq; seg.rx_ack = ak; seg.rx_src_port = src; seg.rx_dst_port = dst;
        tick();
        seg.rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int max);
        int k = 0;
        while (state_out != s && k < max) begin
            tick();
            k++;
        end
        chk(name, 32'(state_out), 32'(s));
    endtask

    task automatic connect(input logic [31:0] isn);
        isn_in = isn;
        exp_q.push_back(mk(1, 0, 0, 0, isn, 32'd0));
        connect_req = 1'b1;
        tick();
        connect_req = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        seg.rx_valid = 1'b0; seg.rx_SYN = 1'b0; seg.rx_ACK = 1'b0; seg.rx_FIN = 1'b0; seg.rx_RST = 1'b0;
        seg.rx_seq = 32'd0; seg.rx_ack = 32'd0; seg.rx_src_port = 16'd0; seg.rx_dst_port = 16'd0;
        seg.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_tx_valid", 32'(seg.tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(seg.rx_ready), 32'd1);
        chk("rst_error", 32'(error_out), 32'd0);
        chk("rst_established", 32'(established_out), 32'd0);
        chk_seg("rst_tx_fields", tx_now(), 100'd0);
        rst = 1'b0;
        tick();

        // Open: isn 0x100, and the peer answers with SYN+ACK seq 0x500 ack 0x101.
        connect(32'h100);
        drain("open_syn");
        exp_q.push_back(mk(0, 1, 0, 0, 32'h101, 32'h501));
        send(1, 1, 0, 0, 32'h500, 32'h101);
        drain("open_ack");
        chk("open_state", 32'(state_out), 32'd2);
        chk("open_established", 32'(established_out), 32'd1);

        // A peer RST in ESTABLISHED closes with one error pulse and emits nothing.
        e0 = err_cnt;
        send(0, 0, 0, 1, 32'h501, 32'd0);
        chk("rst_seg_state", 32'(state_out), 32'd0);
        tick();
        chk("rst_seg_err", err_cnt - e0, 32'd1);

        // Wrap: isn 0xFFFFFFFF, and the peer acks 0x0.
        connect(32'hFFFF_FFFF);
        drain("wrap_syn");
        exp_q.push_back(mk(0, 1, 0, 0, 32'h0, 32'h8));
        send(1, 1, 0, 0, 32'h7, 32'h0);
        drain("wrap_ack");
        chk("wrap_state", 32'(state_out), 32'd2);
        chk("wrap_tx_seq", seg.tx_seq, 32'h0);

        // Active close: FIN+ACK, then the peer sends ACK+FIN and the block ACKs it and holds TIME_WAIT.
        exp_q.push_back(mk(0, 1, 1, 0, 32'h0, 32'h8));
        close_req = 1'b1;
        tick();
        close_req = 1'b0;
        drain("close_fin");
        chk("fw1_state", 32'(state_out), 32'd3);
        exp_q.push_back(mk(0, 1, 0, 0, 32'h1, 32'h9));
        send(0, 1, 1, 0, 32'h8, 32'h1);
        n = 0;
        while (state_out == 3'd5 && n < 100) begin
            n++;
            tick();
        end
        chk("time_wait_cycles", n, 32'd16);
        chk("time_wait_exit", 32'(state_out), 32'd0);
        chk("time_wait_q", exp_q.size(), 32'd0);

        // A wrong ack in SYN_SENT produces an RST and keeps the state; a correct ack then opens the connection.
        connect(32'h300);
        drain("wack_syn");
        exp_q.push_back(mk(0, 0, 0, 1, 32'h999, 32'h0));
        send(1, 1, 0, 0, 32'h900, 32'h999);
        drain("wack_rst");
        chk("wack_state", 32'(state_out), 32'd1);
        exp_q.push_back(mk(0, 1, 0, 0, 32'h301, 32'h901));
        send(1, 1, 0, 0, 32'h900, 32'h301);
        drain("wack_open");
        chk("wack_open_state", 32'(state_out), 32'd2);

        // Backpressure holds the FIN+ACK for 5 cycles, and a wrong-port ACK is then discarded.
        seg.tx_ready = 1'b0;
        exp_q.push_back(mk(0, 1, 1, 0, 32'h301, 32'h901));
        close_req = 1'b1;
        tick();
        close_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rx_ready", 32'(seg.rx_ready), 32'd0);
            chk("bp_tx_valid", 32'(seg.tx_valid), 32'd1);
            tick();
        end
        seg.tx_ready = 1'b1;
        drain("bp_fin");
        send(0, 1, 0, 0, 32'h901, 32'h302, REM, 16'h9999);
        chk("wrong_port_state", 32'(state_out), 32'd3);
        send(0, 1, 0, 0, 32'h901, 32'h302);
        chk("fw2_state", 32'(state_out), 32'd4);
        exp_q.push_back(mk(0, 1, 0, 0, 32'h302, 32'h902));
        send(0, 1, 1, 0, 32'h901, 32'h302);
        chk("fw2_tw_state", 32'(state_out), 32'd5);
        wait_state("fw2_closed", 3'd0, 40);
        chk("fw2_q", exp_q.size(), 32'd0);

        // Passive close: the peer FIN leads to LAST_ACK, and its ACK closes without an error.
        connect(32'h40);
        drain("pass_syn");
        exp_q.push_back(mk(0, 1, 0, 0, 32'h41, 32'h71));
        send(1, 1, 0, 0, 32'h70, 32'h41);
        drain("pass_ack");
        exp_q.push_back(mk(0, 1, 1, 0, 32'h41, 32'h72));
        send(0, 1, 1, 0, 32'h71, 32'h41);
        drain("pass_finack");
        chk("last_ack_state", 32'(state_out), 32'd6);
        e0 = err_cnt;
        send(0, 1, 0, 0, 32'h72, 32'h42);
        chk("pass_closed", 32'(state_out), 32'd0);
        tick();
        chk("pass_no_err", err_cnt - e0, 32'd0);

        // Timeout: with no reply the SYN is sent once and retransmitted 3 times, then the block aborts.
        e0 = err_cnt;
        connect(32'h2000);
        for (int i = 0; i < MR; i++) exp_q.push_back(mk(1, 0, 0, 0, 32'h2000, 32'd0));
        wait_state("tmo_closed", 3'd0, 120);
        repeat (2) tick();
        chk("tmo_err", err_cnt - e0, 32'd1);
        chk("tmo_syn_count", exp_q.size(), 32'd0);
        repeat (12) tick();
        chk("tmo_quiet_state", 32'(state_out), 32'd0);

        // A synchronous reset while a SYN is stalled drops tx_valid on the next edge.
        seg.tx_ready = 1'b0;
        connect(32'h55);
        tick();
        chk("pend_valid", 32'(seg.tx_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("pend_rst_valid", 32'(seg.tx_valid), 32'd0);
        chk("pend_rst_state", 32'(state_out), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        seg.tx_ready = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
